// File: rtl/asconp_round_ctrl_if.sv
// Stream interface of the Ascon round controller: the shared-state input
// channel (state + round count) and the shared-state result channel, each
// with its own valid/ready handshake.
interface asconp_round_ctrl_if #(
    parameter int D = 2
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [3:0]       rounds_i;
    logic [D*64-1:0]  x0_i;
    logic [D*64-1:0]  x1_i;
    logic [D*64-1:0]  x2_i;
    logic [D*64-1:0]  x3_i;
    logic [D*64-1:0]  x4_i;

    logic             out_valid_o;
    logic             out_ready_i;
    logic [D*64-1:0]  x0_o;
    logic [D*64-1:0]  x1_o;
    logic [D*64-1:0]  x2_o;
    logic [D*64-1:0]  x3_o;
    logic [D*64-1:0]  x4_o;

    // Controller side
    modport slave (
        input  in_valid_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
        output in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o
    );

    // Producer/consumer side
    modport master (
        output in_valid_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
        input  in_ready_o, out_valid_o, x0_o, x1_o, x2_o, x3_o, x4_o
    );
endinterface

// File: rtl/asconp_round_ctrl.sv
// Iterative round controller for the masked Ascon permutation. Holds a
// D-share 320-bit state, feeds it and the round counter to asconp, forwards
// fresh randomness, and writes asconp's output back once per 2-cycle round.
// Shares are only ever stored and forwarded, never recombined.
module asconp_round_ctrl #(
    parameter int D        = 2,
    parameter int RDI_BITS = (D - 1) * D / 2
) (
    input  logic                     clk,
    input  logic                     rst,
    asconp_round_ctrl_if.slave       bus,
    input  logic [5*64*RDI_BITS-1:0] rdi_i,
    input  logic                     rdi_valid_i,
    output logic                     rdi_ack_o,
    output logic [3:0]               p_round_cnt_o,
    output logic [5*64*RDI_BITS-1:0] p_rdi_o,
    output logic [D*64-1:0]          p_x0_o,
    output logic [D*64-1:0]          p_x1_o,
    output logic [D*64-1:0]          p_x2_o,
    output logic [D*64-1:0]          p_x3_o,
    output logic [D*64-1:0]          p_x4_o,
    input  logic [D*64-1:0]          p_x0_i,
    input  logic [D*64-1:0]          p_x1_i,
    input  logic [D*64-1:0]          p_x2_i,
    input  logic [D*64-1:0]          p_x3_i,
    input  logic [D*64-1:0]          p_x4_i
);
    localparam int W = D * 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        UPD  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [W-1:0]   x_q [5];
    logic [W-1:0]   x_d [5];
    logic [W-1:0]   x_in [5];
    logic [W-1:0]   x_p [5];
    logic [3:0]     rounds_clamped;

    assign x_in[0] = bus.x0_i;
    assign x_in[1] = bus.x1_i;
    assign x_in[2] = bus.x2_i;
    assign x_in[3] = bus.x3_i;
    assign x_in[4] = bus.x4_i;

    assign x_p[0] = p_x0_i;
    assign x_p[1] = p_x1_i;
    assign x_p[2] = p_x2_i;
    assign x_p[3] = p_x3_i;
    assign x_p[4] = p_x4_i;

    // Anything above a full p12 is treated as p12.
    assign rounds_clamped = (bus.rounds_i > 4'd12) ? 4'd12 : bus.rounds_i;

    // Next-state logic: accept, wait for randomness, write back, present result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 5; i++) begin
            x_d[i] = x_q[i];
        end
        case (state_q)
            IDLE: begin
                if (bus.in_valid_i) begin
                    for (int i = 0; i < 5; i++) begin
                        x_d[i] = x_in[i];
                    end
                    cnt_d   = rounds_clamped;
                    state_d = (rounds_clamped != 4'd0) ? CALC : DONE;
                end
            end
            CALC: begin
                // Without fresh randomness the state is held; the DOM
                // registers inside asconp simply recapture the same values.
                if (rdi_valid_i) begin
                    state_d = UPD;
                end
            end
            UPD: begin
                for (int i = 0; i < 5; i++) begin
                    x_d[i] = x_p[i];
                end
                cnt_d   = cnt_q - 4'd1;
                state_d = (cnt_q == 4'd1) ? DONE : CALC;
            end
            DONE: begin
                if (bus.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, round counter and share registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            for (int i = 0; i < 5; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < 5; i++) begin
                x_q[i] <= x_d[i];
            end
        end
    end

    assign bus.in_ready_o  = (state_q == IDLE);
    assign bus.out_valid_o = (state_q == DONE);

    // Randomness is consumed only on the CALC cycle that moves on to UPD,
    // so exactly one ack per round.
    assign rdi_ack_o     = (state_q == CALC) && rdi_valid_i;

    // Counter stays put through CALC and UPD so asconp sees a stable constant.
    assign p_round_cnt_o = cnt_q;
    assign p_rdi_o       = rdi_i;

    assign p_x0_o = x_q[0];
    assign p_x1_o = x_q[1];
    assign p_x2_o = x_q[2];
    assign p_x3_o = x_q[3];
    assign p_x4_o = x_q[4];

    assign bus.x0_o = x_q[0];
    assign bus.x1_o = x_q[1];
    assign bus.x2_o = x_q[2];
    assign bus.x3_o = x_q[3];
    assign bus.x4_o = x_q[4];
endmodule

// File: tb/tb_asconp_round_ctrl.sv
// Bench for asconp_round_ctrl. Stands in for asconp with a behavioural round
// on the recombined state, and checks results against a reference Ascon
// permutation computed directly from the round index.
module tb_asconp_round_ctrl;
    localparam int D  = 2;
    localparam int W  = D * 64;
    localparam int RW = 5 * 64 * ((D - 1) * D / 2);
    localparam int LIM = 250;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [RW-1:0]  rdi_i = '0;
    logic           rdi_valid_i = 1'b0;
    logic           rdi_ack_o;
    logic [3:0]     p_round_cnt_o;
    logic [RW-1:0]  p_rdi_o;
    logic [W-1:0]   p_x0_o, p_x1_o, p_x2_o, p_x3_o, p_x4_o;
    logic [W-1:0]   p_x0_i, p_x1_i, p_x2_i, p_x3_i, p_x4_i;

    asconp_round_ctrl_if #(.D(D)) bus ();

    asconp_round_ctrl #(.D(D)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .rdi_i(rdi_i), .rdi_valid_i(rdi_valid_i), .rdi_ack_o(rdi_ack_o),
        .p_round_cnt_o(p_round_cnt_o), .p_rdi_o(p_rdi_o),
        .p_x0_o(p_x0_o), .p_x1_o(p_x1_o), .p_x2_o(p_x2_o), .p_x3_o(p_x3_o), .p_x4_o(p_x4_o),
        .p_x0_i(p_x0_i), .p_x1_i(p_x1_i), .p_x2_i(p_x2_i), .p_x3_i(p_x3_i), .p_x4_i(p_x4_i)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One Ascon round on a plain 320-bit state, lane i at [64*i +: 64].
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input int r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        logic [7:0]  c;
        x0 = s[63:0]; x1 = s[127:64]; x2 = s[191:128]; x3 = s[255:192]; x4 = s[319:256];
        c  = 8'(((15 - r) << 4) | r);
        x2 = x2 ^ {56'd0, c};
        x0 ^= x4; x4 ^= x3; x2 ^= x1;
        t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
        x0 ^= t1; x1 ^= t2; x2 ^= t3; x3 ^= t4; x4 ^= t0;
        x1 ^= x0; x0 ^= x4; x3 ^= x2; x2 = ~x2;
        x0 ^= ror(x0, 19) ^ ror(x0, 28);
        x1 ^= ror(x1, 61) ^ ror(x1, 39);
        x2 ^= ror(x2, 1)  ^ ror(x2, 6);
        x3 ^= ror(x3, 10) ^ ror(x3, 17);
        x4 ^= ror(x4, 7)  ^ ror(x4, 41);
        return {x4, x3, x2, x1, x0};
    endfunction

    // Reference permutation: the last n rounds of p12.
    function automatic logic [319:0] perm(input logic [319:0] s, input int n);
        logic [319:0] v;
        v = s;
        for (int i = 12 - n; i < 12; i++) v = ascon_round(v, i);
        return v;
    endfunction

    function automatic logic [319:0] combine(input logic [W-1:0] a0, a1, a2, a3, a4);
        return {a4[127:64] ^ a4[63:0], a3[127:64] ^ a3[63:0], a2[127:64] ^ a2[63:0],
                a1[127:64] ^ a1[63:0], a0[127:64] ^ a0[63:0]};
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Behavioural asconp stand-in: round on the recombined state, re-split
    // with share 1 kept as mask.
    logic [319:0] pm_comb, pm_res;
    always_comb begin
        pm_comb = combine(p_x0_o, p_x1_o, p_x2_o, p_x3_o, p_x4_o);
        pm_res  = ascon_round(pm_comb, 12 - int'(p_round_cnt_o));
        p_x0_i  = {p_x0_o[127:64], pm_res[63:0]    ^ p_x0_o[127:64]};
        p_x1_i  = {p_x1_o[127:64], pm_res[127:64]  ^ p_x1_o[127:64]};
        p_x2_i  = {p_x2_o[127:64], pm_res[191:128] ^ p_x2_o[127:64]};
        p_x3_i  = {p_x3_o[127:64], pm_res[255:192] ^ p_x3_o[127:64]};
        p_x4_i  = {p_x4_o[127:64], pm_res[319:256] ^ p_x4_o[127:64]};
    end

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int rounds;
        int mode;       // rdi_valid pattern: 0 always, 1 = 1,0,0 repeating, 2 random
        bit zero;       // all-zero state instead of random
        int bp;         // cycles of out_ready=0 once the result is valid
        int exp_cnt;    // first p_round_cnt_o seen in CALC
        int exp_const;  // resulting round constant, -1 = not applicable
    } vec_t;

    bit           pat [LIM + 8];
    logic [319:0] smoke_res;

    task automatic fill_pat(input int mode);
        for (int i = 0; i < LIM + 8; i++) begin
            case (mode)
                0:       pat[i] = 1'b1;
                1:       pat[i] = ((i % 3) == 0);
                default: pat[i] = ($urandom_range(0, 3) != 0);
            endcase
        end
    endtask

    // Expected cycles from the accept edge to out_valid under the pattern.
    function automatic int model_lat(input int eff);
        int c;
        c = 0;
        for (int r = 0; r < eff; r++) begin
            while (!pat[c] && c < LIM) c++;
            c += 2;
        end
        return c;
    endfunction

    task automatic drive_state(input logic [319:0] s);
        bus.x0_i = {rnd64(), 64'd0}; bus.x0_i[63:0] = s[63:0]    ^ bus.x0_i[127:64];
        bus.x1_i = {rnd64(), 64'd0}; bus.x1_i[63:0] = s[127:64]  ^ bus.x1_i[127:64];
        bus.x2_i = {rnd64(), 64'd0}; bus.x2_i[63:0] = s[191:128] ^ bus.x2_i[127:64];
        bus.x3_i = {rnd64(), 64'd0}; bus.x3_i[63:0] = s[255:192] ^ bus.x3_i[127:64];
        bus.x4_i = {rnd64(), 64'd0}; bus.x4_i[63:0] = s[319:256] ^ bus.x4_i[127:64];
    endtask

    task automatic run_txn(input vec_t v, input string tag, output logic [319:0] res);
        logic [319:0] s, exp, snap;
        int eff, c, acks, bad_ack, bad_rdi, first_cnt, bad_bp, t;
        s   = '0;
        if (!v.zero) for (int k = 0; k < 10; k++) s[32*k +: 32] = $urandom();
        for (int k = 0; k < RW / 32; k++) rdi_i[32*k +: 32] = $urandom();
        eff = (v.rounds > 12) ? 12 : v.rounds;
        fill_pat(v.mode);
        @(negedge clk);
        chk({tag, ".accept_ready"}, 320'(bus.in_ready_o), 320'd1);
        bus.in_valid_i = 1'b1;
        bus.rounds_i   = 4'(v.rounds);
        drive_state(s);
        rdi_valid_i    = 1'b0;
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        c = 0; acks = 0; bad_ack = 0; bad_rdi = 0; first_cnt = 0;
        while (c < LIM && !bus.out_valid_o) begin
            rdi_valid_i = pat[c];
            #1;
            if (c == 0) first_cnt = int'(p_round_cnt_o);
            if (rdi_ack_o) acks++;
            if (rdi_ack_o && !rdi_valid_i) bad_ack++;
            if (p_rdi_o !== rdi_i) bad_rdi++;
            @(negedge clk);
            c++;
        end
        rdi_valid_i = 1'b0;
        if (c >= LIM) $display("FAIL %s.timeout: no out_valid within %0d cycles", tag, LIM);
        chk({tag, ".out_valid"}, 320'(bus.out_valid_o), 320'd1);
        chk({tag, ".latency"}, 320'(c), 320'(model_lat(eff)));
        chk({tag, ".acks"}, 320'(acks), 320'(eff));
        chk({tag, ".ack_only_valid"}, 320'(bad_ack), 320'd0);
        chk({tag, ".rdi_passthru"}, 320'(bad_rdi), 320'd0);
        chk({tag, ".first_cnt"}, 320'(first_cnt), 320'(v.exp_cnt));
        if (v.exp_const >= 0) begin
            t = 12 - first_cnt;
            chk({tag, ".first_const"}, 320'(((15 - t) << 4) | t), 320'(v.exp_const));
        end
        res = combine(bus.x0_o, bus.x1_o, bus.x2_o, bus.x3_o, bus.x4_o);
        exp = perm(s, eff);
        chk({tag, ".result"}, res, exp);
        if (v.bp > 0) begin
            snap = combine(bus.x0_o, bus.x1_o, bus.x2_o, bus.x3_o, bus.x4_o);
            bad_bp = 0;
            bus.in_valid_i = 1'b1;
            for (int i = 0; i < v.bp; i++) begin
                @(negedge clk);
                if (!bus.out_valid_o || bus.in_ready_o ||
                    combine(bus.x0_o, bus.x1_o, bus.x2_o, bus.x3_o, bus.x4_o) !== snap) bad_bp++;
            end
            bus.in_valid_i = 1'b0;
            chk({tag, ".bp_hold"}, 320'(bad_bp), 320'd0);
        end
        bus.out_ready_i = 1'b1;
        @(negedge clk);
        bus.out_ready_i = 1'b0;
        chk({tag, ".handshake"}, {318'd0, bus.out_valid_o, bus.in_ready_o}, 320'b01);
    endtask

    vec_t vecs [7];
    logic [319:0] res;
    vec_t rv;

    initial begin
        vecs[0] = '{12, 0, 1'b1, 0,  12, 'hF0};
        vecs[1] = '{6,  2, 1'b0, 0,  6,  'h96};
        vecs[2] = '{8,  0, 1'b0, 0,  8,  'hB4};
        vecs[3] = '{12, 1, 1'b1, 0,  12, 'hF0};
        vecs[4] = '{12, 0, 1'b0, 10, 12, 'hF0};
        vecs[5] = '{0,  0, 1'b0, 0,  0,  -1};
        vecs[6] = '{15, 0, 1'b0, 0,  12, 'hF0};

        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b0;
        bus.rounds_i    = 4'd0;
        drive_state('0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.in_ready", 320'(bus.in_ready_o), 320'd1);
        chk("reset.out_valid", 320'(bus.out_valid_o), 320'd0);
        chk("reset.rdi_ack", 320'(rdi_ack_o), 320'd0);
        chk("reset.round_cnt", 320'(p_round_cnt_o), 320'd0);
        chk("reset.state", combine(bus.x0_o, bus.x1_o, bus.x2_o, bus.x3_o, bus.x4_o) |
            {bus.x0_o[63:0], bus.x1_o[63:0], bus.x2_o[63:0], bus.x3_o[63:0], bus.x4_o[63:0]}, '0);

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i], $sformatf("vec%0d", i), res);
            if (i == 0) smoke_res = res;
            if (i == 3) chk("stall_vs_smoke", res, smoke_res);
        end

        // Reset in the write-back cycle of round 5 of a p12.
        fill_pat(0);
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.rounds_i   = 4'd12;
        drive_state({10{$urandom()}});
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        rdi_valid_i    = 1'b1;
        repeat (9) @(negedge clk);
        chk("midrst.cnt_r5", 320'(p_round_cnt_o), 320'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst.in_ready", 320'(bus.in_ready_o), 320'd1);
        chk("midrst.out_valid", 320'(bus.out_valid_o), 320'd0);
        chk("midrst.rdi_ack", 320'(rdi_ack_o), 320'd0);
        chk("midrst.state0", {bus.x4_o, bus.x3_o, bus.x2_o[63:0]} |
            {64'd0, bus.x2_o[127:64], bus.x1_o, bus.x0_o}, '0);
        rdi_valid_i = 1'b0;
        run_txn(vecs[0], "after_rst", res);
        chk("after_rst_vs_smoke", res, smoke_res);

        // Randomized transactions.
        for (int i = 0; i < 20; i++) begin
            rv.rounds    = $urandom_range(0, 15);
            rv.mode      = 2;
            rv.zero      = 1'b0;
            rv.bp        = $urandom_range(0, 3);
            rv.exp_cnt   = (rv.rounds > 12) ? 12 : rv.rounds;
            rv.exp_const = -1;
            run_txn(rv, $sformatf("rnd%0d", i), res);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
